// File: rtl/brq_result_monitor.sv
// brq_result_monitor: per-channel debounce of core result taps and a sticky pass/fail/timeout verdict.
// Latency: a value counts one cycle after its StableCycles-th matching sample; the verdict is registered one edge later.
// Backpressure: none. Samples are observed only while a run is active and are ignored in every other state.
module brq_result_monitor #(
  parameter int                   DataWidth     = 32,
  parameter int                   NumChannels   = 1,
  parameter logic [DataWidth-1:0] PassValue     = 32'h0000_0001,
  parameter logic [DataWidth-1:0] FailValue     = 32'hDEAD_0BAD,
  parameter int                   StableCycles  = 4,
  parameter int                   TimeoutCycles = 100000,
  parameter bit                   PassAll       = 1'b0,
  parameter int                   CntWidth      = 32,
  localparam int                  ChanWidth     = (NumChannels > 1) ? $clog2(NumChannels) : 1
) (
  input  logic                             brq_clk,
  input  logic                             brq_rst,
  input  logic                             start_i,
  input  logic [NumChannels-1:0]           valid_i,
  input  logic [NumChannels*DataWidth-1:0] data_i,
  output logic                             busy_o,
  output logic                             done_o,
  output logic                             pass_o,
  output logic                             fail_o,
  output logic                             timeout_o,
  output logic [ChanWidth-1:0]             fail_chan_o,
  output logic [DataWidth-1:0]             fail_data_o,
  output logic [CntWidth-1:0]              cycles_o
);

  localparam int                 StCntW    = $clog2(StableCycles + 1);
  localparam logic [StCntW-1:0]  StableMax = StCntW'(StableCycles);
  localparam logic [CntWidth-1:0] LastCycle = CntWidth'(TimeoutCycles - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_PASS,
    S_FAIL,
    S_TIMEOUT
  } state_t;

  state_t                 state_q;
  state_t                 state_d;
  logic                   armed_q;
  logic                   start;

  logic [StCntW-1:0]      cnt_q  [NumChannels];
  logic [DataWidth-1:0]   last_q [NumChannels];
  logic [NumChannels-1:0] seen_q;

  logic [DataWidth-1:0]   chan_dat [NumChannels];
  logic [NumChannels-1:0] stable;
  logic [NumChannels-1:0] pass_hit;
  logic [NumChannels-1:0] fail_hit;
  logic [NumChannels-1:0] seen_now;
  logic                   pass_ok;
  logic                   timeout_hit;
  logic [ChanWidth-1:0]   fail_sel;
  logic [DataWidth-1:0]   fail_val;
  logic [ChanWidth-1:0]   fail_chan_d;
  logic [DataWidth-1:0]   fail_data_d;

  // A start pulse on the very first edge after reset release is dropped, so
  // a start that overlaps reset deassertion never launches a run.
  assign start = start_i & armed_q;

  // Arm start detection one edge after reset release.
  always_ff @(posedge brq_clk or negedge brq_rst) begin
    if (!brq_rst) begin
      armed_q <= 1'b0;
    end else begin
      armed_q <= 1'b1;
    end
  end

  // Unpack channels and classify each one from its registered debounce state.
  always_comb begin
    for (int c = 0; c < NumChannels; c++) begin
      chan_dat[c] = data_i[c*DataWidth +: DataWidth];
      stable[c]   = (cnt_q[c] == StableMax);
      pass_hit[c] = stable[c] && (last_q[c] == PassValue);
      fail_hit[c] = stable[c] && (last_q[c] == FailValue);
    end
  end

  // Pass condition counts a channel reaching PassValue in this same cycle.
  always_comb begin
    seen_now    = seen_q | pass_hit;
    pass_ok     = PassAll ? (&seen_now) : (|seen_now);
    timeout_hit = (cycles_o == LastCycle);
  end

  // Lowest-index failing channel: scan downwards so the lowest hit wins.
  always_comb begin
    fail_sel = '0;
    fail_val = '0;
    for (int c = NumChannels - 1; c >= 0; c--) begin
      if (fail_hit[c]) begin
        fail_sel = ChanWidth'(c);
        fail_val = last_q[c];
      end
    end
  end

  // Next-state and failure capture; fail outranks pass, both outrank timeout.
  always_comb begin
    state_d     = state_q;
    fail_chan_d = fail_chan_o;
    fail_data_d = fail_data_o;
    if (start) begin
      state_d     = S_RUN;
      fail_chan_d = '0;
      fail_data_d = '0;
    end else if (state_q == S_RUN) begin
      if (|fail_hit) begin
        state_d     = S_FAIL;
        fail_chan_d = fail_sel;
        fail_data_d = fail_val;
      end else if (pass_ok) begin
        state_d = S_PASS;
      end else if (timeout_hit) begin
        state_d = S_TIMEOUT;
      end
    end
  end

  // State register.
  always_ff @(posedge brq_clk or negedge brq_rst) begin
    if (!brq_rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Registered status outputs, decoded from the next state so they track state_q exactly.
  always_ff @(posedge brq_clk or negedge brq_rst) begin
    if (!brq_rst) begin
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      pass_o      <= 1'b0;
      fail_o      <= 1'b0;
      timeout_o   <= 1'b0;
      fail_chan_o <= '0;
      fail_data_o <= '0;
    end else begin
      busy_o      <= (state_d == S_RUN);
      done_o      <= (state_d == S_PASS) || (state_d == S_FAIL) || (state_d == S_TIMEOUT);
      pass_o      <= (state_d == S_PASS);
      fail_o      <= (state_d == S_FAIL);
      timeout_o   <= (state_d == S_TIMEOUT);
      fail_chan_o <= fail_chan_d;
      fail_data_o <= fail_data_d;
    end
  end

  // Cycle counter: saturating, frozen outside RUN, held at the budget's last
  // value when the run times out so it reads TimeoutCycles-1.
  always_ff @(posedge brq_clk or negedge brq_rst) begin
    if (!brq_rst) begin
      cycles_o <= '0;
    end else if (start) begin
      cycles_o <= '0;
    end else if ((state_q == S_RUN) && (state_d != S_TIMEOUT) && (cycles_o != '1)) begin
      cycles_o <= cycles_o + 1'b1;
    end
  end

  // Per-channel debounce counters, last values and sticky pass_seen bits.
  always_ff @(posedge brq_clk or negedge brq_rst) begin
    if (!brq_rst) begin
      seen_q <= '0;
      for (int c = 0; c < NumChannels; c++) begin
        cnt_q[c]  <= '0;
        last_q[c] <= '0;
      end
    end else if (start) begin
      seen_q <= '0;
      for (int c = 0; c < NumChannels; c++) begin
        cnt_q[c]  <= '0;
        last_q[c] <= '0;
      end
    end else if (state_q == S_RUN) begin
      seen_q <= seen_now;
      for (int c = 0; c < NumChannels; c++) begin
        if (!valid_i[c]) begin
          cnt_q[c] <= '0;
        end else if (chan_dat[c] != last_q[c]) begin
          cnt_q[c]  <= StCntW'(1);
          last_q[c] <= chan_dat[c];
        end else if (cnt_q[c] != StableMax) begin
          cnt_q[c] <= cnt_q[c] + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_brq_result_monitor.sv
// Testbench for brq_result_monitor: two instances (any-pass and all-pass) share one stimulus.
// Each output is checked every cycle against a run-length based reference model.
// Directed scenarios pin down the exact cycle counts from the verdict timing rules.
module tb_brq_result_monitor;

  localparam int          NCH   = 4;
  localparam int          DW    = 32;
  localparam int          STAB  = 4;
  localparam int          TMO   = 50;
  localparam int          CW    = 16;
  localparam logic [31:0] PASSV = 32'h0000_0001;
  localparam logic [31:0] FAILV = 32'hDEAD_0BAD;

  localparam int ST_IDLE = 0;
  localparam int ST_RUN  = 1;
  localparam int ST_PASS = 2;
  localparam int ST_FAIL = 3;
  localparam int ST_TOUT = 4;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [NCH-1:0]    valid;
  logic [NCH*DW-1:0] data;

  logic          busy_w [2];
  logic          done_w [2];
  logic          pass_w [2];
  logic          fail_w [2];
  logic          tout_w [2];
  logic [1:0]    fch_w  [2];
  logic [DW-1:0] fdat_w [2];
  logic [CW-1:0] cyc_w  [2];
  logic [54:0]   obs    [2];

  int ncmp  = 0;
  int nfail = 0;

  // Reference model state, one copy per instance.
  int          m_st   [2];
  int          m_cyc  [2];
  int          m_fch  [2];
  logic [31:0] m_fdat [2];
  int          m_run  [2][NCH];
  logic [31:0] m_last [2][NCH];
  bit          m_seen [2][NCH];
  bit          m_armed;

  brq_result_monitor #(
    .DataWidth(DW), .NumChannels(NCH), .PassValue(PASSV), .FailValue(FAILV),
    .StableCycles(STAB), .TimeoutCycles(TMO), .PassAll(1'b0), .CntWidth(CW)
  ) dut_any (
    .brq_clk(clk), .brq_rst(rst_n), .start_i(start), .valid_i(valid), .data_i(data),
    .busy_o(busy_w[0]), .done_o(done_w[0]), .pass_o(pass_w[0]), .fail_o(fail_w[0]),
    .timeout_o(tout_w[0]), .fail_chan_o(fch_w[0]), .fail_data_o(fdat_w[0]), .cycles_o(cyc_w[0])
  );

  brq_result_monitor #(
    .DataWidth(DW), .NumChannels(NCH), .PassValue(PASSV), .FailValue(FAILV),
    .StableCycles(STAB), .TimeoutCycles(TMO), .PassAll(1'b1), .CntWidth(CW)
  ) dut_all (
    .brq_clk(clk), .brq_rst(rst_n), .start_i(start), .valid_i(valid), .data_i(data),
    .busy_o(busy_w[1]), .done_o(done_w[1]), .pass_o(pass_w[1]), .fail_o(fail_w[1]),
    .timeout_o(tout_w[1]), .fail_chan_o(fch_w[1]), .fail_data_o(fdat_w[1]), .cycles_o(cyc_w[1])
  );

  assign obs[0] = {busy_w[0], done_w[0], pass_w[0], fail_w[0], tout_w[0], fch_w[0], fdat_w[0], cyc_w[0]};
  assign obs[1] = {busy_w[1], done_w[1], pass_w[1], fail_w[1], tout_w[1], fch_w[1], fdat_w[1], cyc_w[1]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [54:0] exp_vec(input int m);
    logic is_fail;
    is_fail = (m_st[m] == ST_FAIL);
    return {m_st[m] == ST_RUN,
            (m_st[m] == ST_PASS) || (m_st[m] == ST_FAIL) || (m_st[m] == ST_TOUT),
            m_st[m] == ST_PASS, is_fail, m_st[m] == ST_TOUT,
            is_fail ? 2'(m_fch[m]) : 2'b00,
            is_fail ? m_fdat[m] : 32'h0,
            CW'(m_cyc[m])};
  endfunction

  function automatic logic [NCH*DW-1:0] pack4(input logic [31:0] a, input logic [31:0] b,
                                              input logic [31:0] c, input logic [31:0] d);
    return {d, c, b, a};
  endfunction

  task automatic model_reset();
    m_armed = 1'b0;
    for (int m = 0; m < 2; m++) begin
      m_st[m] = ST_IDLE; m_cyc[m] = 0; m_fch[m] = 0; m_fdat[m] = '0;
      for (int c = 0; c < NCH; c++) begin
        m_run[m][c] = 0; m_last[m][c] = '0; m_seen[m][c] = 1'b0;
      end
    end
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_edge();
    int          first_fail;
    bit          any_ok;
    bit          all_ok;
    bit          hit [NCH];
    logic [31:0] d;
    if (!m_armed) begin
      m_armed = 1'b1;
      return;
    end
    for (int m = 0; m < 2; m++) begin
      if (start) begin
        m_st[m] = ST_RUN; m_cyc[m] = 0; m_fch[m] = 0; m_fdat[m] = '0;
        for (int c = 0; c < NCH; c++) begin
          m_run[m][c] = 0; m_last[m][c] = '0; m_seen[m][c] = 1'b0;
        end
        continue;
      end
      if (m_st[m] != ST_RUN) continue;
      first_fail = -1; any_ok = 1'b0; all_ok = 1'b1;
      for (int c = 0; c < NCH; c++) begin
        hit[c] = (m_run[m][c] >= STAB) && (m_last[m][c] == PASSV);
        if ((m_run[m][c] >= STAB) && (m_last[m][c] == FAILV) && (first_fail < 0)) first_fail = c;
        if (m_seen[m][c] || hit[c]) any_ok = 1'b1;
        else all_ok = 1'b0;
      end
      if (first_fail >= 0) begin
        m_st[m] = ST_FAIL; m_fch[m] = first_fail; m_fdat[m] = m_last[m][first_fail];
      end else if ((m == 1) ? all_ok : any_ok) begin
        m_st[m] = ST_PASS;
      end else if (m_cyc[m] == TMO - 1) begin
        m_st[m] = ST_TOUT;
      end
      if (m_st[m] != ST_TOUT) m_cyc[m]++;
      for (int c = 0; c < NCH; c++) begin
        if (hit[c]) m_seen[m][c] = 1'b1;
        d = data[c*DW +: DW];
        if (!valid[c]) m_run[m][c] = 0;
        else if (d != m_last[m][c]) begin m_run[m][c] = 1; m_last[m][c] = d; end
        else m_run[m][c]++;
      end
    end
  endtask

  // Drive one cycle of inputs, step the model, then sample just after the edge.
  task automatic tick(input logic s, input logic [NCH-1:0] v, input logic [NCH*DW-1:0] d);
    start = s; valid = v; data = d;
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; valid = '0; data = '0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    for (int m = 0; m < 2; m++) begin
      ncmp++;
      if (obs[m] !== 55'h0) begin
        nfail++; $display("FAIL reset_state inst%0d got %h want 0", m, obs[m]);
      end
    end
    rst_n = 1'b1;
    tick(1'b1, '0, '0);
    for (int i = 0; i < 4; i++) begin
      for (int m = 0; m < 2; m++) begin
        ncmp++;
        if (obs[m] !== exp_vec(m) || busy_w[m] !== 1'b0) begin
          nfail++; $display("FAIL start_at_release[%0d] inst%0d got %h want %h", i, m, obs[m], exp_vec(m));
        end
      end
      tick(1'b0, '0, '0);
    end
  endtask

  task automatic test_basic();
    logic [31:0] seq [6];
    seq = '{32'd5, 32'd5, 32'd1, 32'd1, 32'd1, 32'd1};
    tick(1'b1, '0, '0);
    for (int i = 0; i < 7; i++) begin
      if (i < 6) tick(1'b0, 4'b0001, pack4(seq[i], 0, 0, 0));
      else tick(1'b0, 4'b0000, '0);
      for (int m = 0; m < 2; m++) begin
        ncmp++;
        if (obs[m] !== exp_vec(m)) begin
          nfail++; $display("FAIL basic[%0d] inst%0d got %h want %h", i, m, obs[m], exp_vec(m));
        end
      end
      if (i == 5) begin
        ncmp++;
        if (done_w[0] !== 1'b0) begin
          nfail++; $display("FAIL basic_early_done got %b want 0", done_w[0]);
        end
      end
    end
    ncmp++;
    if ({pass_w[0], done_w[0], fail_w[0], tout_w[0], busy_w[0]} !== 5'b11000 || cyc_w[0] !== 16'd7) begin
      nfail++; $display("FAIL basic_verdict got p/d/f/t/b=%b%b%b%b%b cyc=%0d want 11000 cyc=7",
                        pass_w[0], done_w[0], fail_w[0], tout_w[0], busy_w[0], cyc_w[0]);
    end
    tick(1'b0, 4'b0001, pack4(32'd9, 0, 0, 0));
    ncmp++;
    if (cyc_w[0] !== 16'd7 || pass_w[0] !== 1'b1) begin
      nfail++; $display("FAIL basic_frozen got cyc=%0d pass=%b want cyc=7 pass=1", cyc_w[0], pass_w[0]);
    end
  endtask

  task automatic test_glitch();
    int seq [12];
    seq = '{1, 1, 1, 2, 1, 1, 1, -1, 1, 1, 1, 1};
    tick(1'b1, '0, '0);
    for (int i = 0; i < 13; i++) begin
      if (i < 12 && seq[i] >= 0) tick(1'b0, 4'b0001, pack4(32'(seq[i]), 0, 0, 0));
      else tick(1'b0, 4'b0000, '0);
      for (int m = 0; m < 2; m++) begin
        ncmp++;
        if (obs[m] !== exp_vec(m)) begin
          nfail++; $display("FAIL glitch[%0d] inst%0d got %h want %h", i, m, obs[m], exp_vec(m));
        end
      end
      ncmp++;
      if (pass_w[0] !== (i == 12)) begin
        nfail++; $display("FAIL glitch_pass[%0d] got %b want %b", i, pass_w[0], (i == 12));
      end
    end
    ncmp++;
    if (cyc_w[0] !== 16'd13) begin
      nfail++; $display("FAIL glitch_cycles got %0d want 13", cyc_w[0]);
    end
  endtask

  task automatic test_pass_all();
    logic [NCH-1:0]    v;
    logic [NCH*DW-1:0] d;
    tick(1'b1, '0, '0);
    for (int i = 1; i <= 46; i++) begin
      v = '0; d = '0;
      for (int c = 0; c < NCH; c++) begin
        if (i >= 10 * (c + 1)) begin
          v[c] = 1'b1;
          d[c*DW +: DW] = (c == 0 && i >= 20) ? 32'd7 : PASSV;
        end
      end
      tick(1'b0, v, d);
      for (int m = 0; m < 2; m++) begin
        ncmp++;
        if (obs[m] !== exp_vec(m)) begin
          nfail++; $display("FAIL pass_all[%0d] inst%0d got %h want %h", i, m, obs[m], exp_vec(m));
        end
      end
      if (i == 43) begin
        ncmp++;
        if (pass_w[1] !== 1'b0) begin
          nfail++; $display("FAIL pass_all_early got %b want 0", pass_w[1]);
        end
      end
    end
    ncmp++;
    if (pass_w[1] !== 1'b1 || cyc_w[1] !== 16'd44 || pass_w[0] !== 1'b1 || cyc_w[0] !== 16'd14) begin
      nfail++; $display("FAIL pass_all_verdict got all=%b/%0d any=%b/%0d want 1/44 1/14",
                        pass_w[1], cyc_w[1], pass_w[0], cyc_w[0]);
    end
  endtask

  task automatic test_fail_priority();
    tick(1'b1, '0, '0);
    for (int i = 1; i <= 6; i++) begin
      tick(1'b0, 4'b0110, pack4(0, PASSV, FAILV, 0));
      for (int m = 0; m < 2; m++) begin
        ncmp++;
        if (obs[m] !== exp_vec(m)) begin
          nfail++; $display("FAIL fail_prio[%0d] inst%0d got %h want %h", i, m, obs[m], exp_vec(m));
        end
      end
    end
    for (int m = 0; m < 2; m++) begin
      ncmp++;
      if (fail_w[m] !== 1'b1 || pass_w[m] !== 1'b0 || fch_w[m] !== 2'd2 || fdat_w[m] !== FAILV) begin
        nfail++; $display("FAIL fail_prio_verdict inst%0d got f=%b p=%b ch=%0d dat=%h want 1 0 2 deadbad",
                          m, fail_w[m], pass_w[m], fch_w[m], fdat_w[m]);
      end
    end
  endtask

  task automatic test_timeout();
    tick(1'b1, '0, '0);
    for (int i = 1; i <= 52; i++) begin
      tick(1'b0, '0, '0);
      for (int m = 0; m < 2; m++) begin
        ncmp++;
        if (obs[m] !== exp_vec(m)) begin
          nfail++; $display("FAIL timeout[%0d] inst%0d got %h want %h", i, m, obs[m], exp_vec(m));
        end
      end
    end
    ncmp++;
    if (tout_w[0] !== 1'b1 || busy_w[0] !== 1'b0 || cyc_w[0] !== 16'd49 || done_w[0] !== 1'b1) begin
      nfail++; $display("FAIL timeout_verdict got t=%b b=%b d=%b cyc=%0d want 1 0 1 49",
                        tout_w[0], busy_w[0], done_w[0], cyc_w[0]);
    end
    tick(1'b1, '0, '0);
    ncmp++;
    if (tout_w[0] !== 1'b0 || done_w[0] !== 1'b0 || busy_w[0] !== 1'b1 || cyc_w[0] !== 16'd0) begin
      nfail++; $display("FAIL timeout_restart got t=%b d=%b b=%b cyc=%0d want 0 0 1 0",
                        tout_w[0], done_w[0], busy_w[0], cyc_w[0]);
    end
    tick(1'b0, '0, '0);
    ncmp++;
    if (cyc_w[0] !== 16'd1) begin
      nfail++; $display("FAIL timeout_recount got %0d want 1", cyc_w[0]);
    end
  endtask

  task automatic test_async_reset();
    tick(1'b1, '0, '0);
    for (int i = 0; i < 5; i++) tick(1'b0, 4'b0001, pack4(PASSV, 0, 0, 0));
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    for (int m = 0; m < 2; m++) begin
      ncmp++;
      if (obs[m] !== 55'h0) begin
        nfail++; $display("FAIL async_reset inst%0d got %h want 0", m, obs[m]);
      end
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick(1'b1, 4'b0001, pack4(PASSV, 0, 0, 0));
    for (int i = 0; i < 6; i++) begin
      for (int m = 0; m < 2; m++) begin
        ncmp++;
        if (obs[m] !== exp_vec(m) || obs[m] !== 55'h0) begin
          nfail++; $display("FAIL post_reset_idle[%0d] inst%0d got %h want 0", i, m, obs[m]);
        end
      end
      tick(1'b0, 4'b0001, pack4(PASSV, 0, 0, 0));
    end
  endtask

  task automatic test_random();
    logic [31:0]       cur [NCH];
    logic [NCH-1:0]    v;
    logic [NCH*DW-1:0] d;
    int                len;
    int                pick;
    for (int r = 0; r < 30; r++) begin
      for (int c = 0; c < NCH; c++) cur[c] = 32'($urandom_range(0, 3));
      tick(1'b1, '0, '0);
      len = $urandom_range(8, 70);
      for (int i = 0; i < len; i++) begin
        v = '0; d = '0;
        for (int c = 0; c < NCH; c++) begin
          if ($urandom_range(0, 4) == 0) begin
            pick = $urandom_range(0, 11);
            if (pick < 4) cur[c] = PASSV;
            else if (pick == 4) cur[c] = FAILV;
            else if (pick < 10) cur[c] = 32'($urandom_range(0, 3));
            else cur[c] = $urandom;
          end
          v[c] = ($urandom_range(0, 7) != 0);
          d[c*DW +: DW] = cur[c];
        end
        tick(($urandom_range(0, 63) == 0), v, d);
        for (int m = 0; m < 2; m++) begin
          ncmp++;
          if (obs[m] !== exp_vec(m)) begin
            nfail++; $display("FAIL random[%0d.%0d] inst%0d got %h want %h", r, i, m, obs[m], exp_vec(m));
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_pass_all();
    test_fail_priority();
    test_timeout();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
